// File: rtl/peripheral_bus_arbiter_pkg.sv
// Shared peripheral-bus definitions: bus widths, arbiter state encoding and
// the lastGrant owner encoding used by the arbiter and future bridges.
package peripheral_bus_arbiter_pkg;

    localparam int unsigned ADDRESS_WIDTH     = 24;
    localparam int unsigned DATA_WIDTH        = 32;
    localparam int unsigned BYTE_SELECT_WIDTH = 4;
    localparam int unsigned COUNT_WIDTH       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    // Owner of the most recently completed grant.
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/peripheral_bus_timeout.sv
// Saturating 8-bit stall counter for bus bridges.
// Ports: clk, rst (sync, active-high), clear (highest priority after rst),
//        enable (count one stall cycle), expired (count == LIMIT-1).
module peripheral_bus_timeout
    import peripheral_bus_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [COUNT_WIDTH-1:0] count;

    // Counter never wraps: it holds at all-ones if left enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {COUNT_WIDTH{1'b1}})) begin
            count <= count + COUNT_WIDTH'(1);
        end
    end

    assign expired = (count == COUNT_WIDTH'(LIMIT - 1));

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral bus between requester A
// (management bridge) and requester B (core data port). A grant is held for
// the whole transfer; a stall timeout aborts transfers a peripheral never ends.
// Ports: clk, rst (sync, active-high); a_*/b_* requester buses (we/oe strobes,
//        address, byteSelect, dataWrite in; dataRead, busy out);
//        peripheralBus_* downstream bus; timeoutFlag pulses on an abort.
module peripheral_bus_arbiter
    import peripheral_bus_arbiter_pkg::*;
#(
    parameter int unsigned            TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0]  TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_we,
    input  logic                         a_oe,
    input  logic [ADDRESS_WIDTH-1:0]     a_address,
    input  logic [BYTE_SELECT_WIDTH-1:0] a_byteSelect,
    input  logic [DATA_WIDTH-1:0]        a_dataWrite,
    output logic [DATA_WIDTH-1:0]        a_dataRead,
    output logic                         a_busy,
    input  logic                         b_we,
    input  logic                         b_oe,
    input  logic [ADDRESS_WIDTH-1:0]     b_address,
    input  logic [BYTE_SELECT_WIDTH-1:0] b_byteSelect,
    input  logic [DATA_WIDTH-1:0]        b_dataWrite,
    output logic [DATA_WIDTH-1:0]        b_dataRead,
    output logic                         b_busy,
    output logic                         peripheralBus_we,
    output logic                         peripheralBus_oe,
    output logic [ADDRESS_WIDTH-1:0]     peripheralBus_address,
    output logic [BYTE_SELECT_WIDTH-1:0] peripheralBus_byteSelect,
    output logic [DATA_WIDTH-1:0]        peripheralBus_dataWrite,
    input  logic [DATA_WIDTH-1:0]        peripheralBus_dataRead,
    input  logic                         peripheralBus_busy,
    output logic                         timeoutFlag
);

    arb_state_t state, next_state;
    logic       last_grant, next_last_grant;

    logic req_a, req_b, req_granted;
    logic stall, expired, abort, finish;

    assign req_a = a_we | a_oe;
    assign req_b = b_we | b_oe;

    assign req_granted = ((state == GRANT_A) && req_a) || ((state == GRANT_B) && req_b);
    assign stall       = req_granted & peripheralBus_busy;
    assign abort       = stall & expired;
    // Transfer ends this cycle, either normally or by timeout.
    assign finish      = req_granted & (~peripheralBus_busy | expired);

    // Any non-stall cycle clears, so the count restarts on every grant change.
    peripheral_bus_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (~(stall & ~expired)),
        .enable  (stall & ~expired),
        .expired (expired)
    );

    // State and round-robin owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= OWNER_B;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    // Next-state and bus steering.
    always_comb begin
        next_state               = state;
        next_last_grant          = last_grant;
        peripheralBus_we         = 1'b0;
        peripheralBus_oe         = 1'b0;
        peripheralBus_address    = '0;
        peripheralBus_byteSelect = '0;
        peripheralBus_dataWrite  = '0;
        a_dataRead               = '0;
        b_dataRead               = '0;
        a_busy                   = req_a;
        b_busy                   = req_b;
        timeoutFlag              = 1'b0;

        // Outputs stay quiet while rst is held, even if a grant is still registered.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_a && (!req_b || (last_grant == OWNER_B))) begin
                        next_state = GRANT_A;
                    end else if (req_b) begin
                        next_state = GRANT_B;
                    end
                end

                GRANT_A: begin
                    peripheralBus_we         = a_we & ~abort;
                    peripheralBus_oe         = a_oe & ~abort;
                    peripheralBus_address    = a_address;
                    peripheralBus_byteSelect = a_byteSelect;
                    peripheralBus_dataWrite  = a_dataWrite;
                    a_dataRead               = abort ? TIMEOUT_DATA : peripheralBus_dataRead;
                    a_busy                   = peripheralBus_busy & ~abort;
                    timeoutFlag              = abort;
                    if (!req_a) begin
                        next_state = IDLE;
                    end else if (finish) begin
                        next_last_grant = OWNER_A;
                        next_state      = req_b ? GRANT_B : IDLE;
                    end
                end

                GRANT_B: begin
                    peripheralBus_we         = b_we & ~abort;
                    peripheralBus_oe         = b_oe & ~abort;
                    peripheralBus_address    = b_address;
                    peripheralBus_byteSelect = b_byteSelect;
                    peripheralBus_dataWrite  = b_dataWrite;
                    b_dataRead               = abort ? TIMEOUT_DATA : peripheralBus_dataRead;
                    b_busy                   = peripheralBus_busy & ~abort;
                    timeoutFlag              = abort;
                    if (!req_b) begin
                        next_state = IDLE;
                    end else if (finish) begin
                        next_last_grant = OWNER_B;
                        next_state      = req_a ? GRANT_A : IDLE;
                    end
                end

                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed bench for peripheral_bus_arbiter: reset, single read, tie-break
// ordering, busy stall, timeout abort, withdraw and mid-transfer reset.
module tb_peripheral_bus_arbiter;
    import peripheral_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we, a_oe, b_we, b_oe;
    logic [23:0] a_address, b_address;
    logic [3:0]  a_byteSelect, b_byteSelect;
    logic [31:0] a_dataWrite, b_dataWrite;
    logic [31:0] a_dataRead, b_dataRead;
    logic        a_busy, b_busy;
    logic        peripheralBus_we, peripheralBus_oe;
    logic [23:0] peripheralBus_address;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataWrite;
    logic [31:0] peripheralBus_dataRead;
    logic        peripheralBus_busy;
    logic        timeoutFlag;

    int errors = 0;
    int checks = 0;

    peripheral_bus_arbiter #(
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_DATA   (32'hFFFF_FFFF)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .a_we                     (a_we),
        .a_oe                     (a_oe),
        .a_address                (a_address),
        .a_byteSelect             (a_byteSelect),
        .a_dataWrite              (a_dataWrite),
        .a_dataRead               (a_dataRead),
        .a_busy                   (a_busy),
        .b_we                     (b_we),
        .b_oe                     (b_oe),
        .b_address                (b_address),
        .b_byteSelect             (b_byteSelect),
        .b_dataWrite              (b_dataWrite),
        .b_dataRead               (b_dataRead),
        .b_busy                   (b_busy),
        .peripheralBus_we         (peripheralBus_we),
        .peripheralBus_oe         (peripheralBus_oe),
        .peripheralBus_address    (peripheralBus_address),
        .peripheralBus_byteSelect (peripheralBus_byteSelect),
        .peripheralBus_dataWrite  (peripheralBus_dataWrite),
        .peripheralBus_dataRead   (peripheralBus_dataRead),
        .peripheralBus_busy       (peripheralBus_busy),
        .timeoutFlag              (timeoutFlag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic chk1(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_we = 1'b0; a_oe = 1'b0; b_we = 1'b0; b_oe = 1'b0;
        a_address = '0; b_address = '0;
        a_byteSelect = 4'hF; b_byteSelect = 4'hF;
        a_dataWrite = '0; b_dataWrite = '0;
        peripheralBus_dataRead = '0;
        peripheralBus_busy = 1'b0;

        // Reset: busy mirrors request, downstream silent.
        tick();
        tick();
        a_oe = 1'b1;
        #1;
        chk1("rst_a_busy", a_busy, 1'b1);
        chk1("rst_pb_oe", peripheralBus_oe, 1'b0);
        chk("rst_a_dataRead", a_dataRead, 32'h0);
        chk1("rst_flag", timeoutFlag, 1'b0);
        a_oe = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_pb_addr", 32'(peripheralBus_address), 32'h0);

        // Single read by A.
        a_oe = 1'b1; a_address = 24'h03_0010;
        peripheralBus_dataRead = 32'h0000_00A5;
        #1;
        chk1("rd_arb_a_busy", a_busy, 1'b1);
        chk1("rd_arb_pb_oe", peripheralBus_oe, 1'b0);
        tick();
        chk1("rd_pb_oe", peripheralBus_oe, 1'b1);
        chk("rd_pb_addr", 32'(peripheralBus_address), 32'h0003_0010);
        chk1("rd_a_busy", a_busy, 1'b0);
        chk("rd_a_dataRead", a_dataRead, 32'h0000_00A5);
        chk("rd_b_dataRead", b_dataRead, 32'h0);
        tick();
        a_oe = 1'b0;
        #1;
        chk("rd_state_idle", 32'(dut.state), 32'(IDLE));
        chk1("rd_idle_pb_oe", peripheralBus_oe, 1'b0);

        // Tie after reset: A then B back to back, then again A then B.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_we = 1'b1; a_address = 24'h01_0004; a_dataWrite = 32'h1234_5678;
        b_oe = 1'b1; b_address = 24'h02_0008;
        peripheralBus_dataRead = 32'h0000_BEEF;
        #1;
        chk1("tie_arb_a_busy", a_busy, 1'b1);
        chk1("tie_arb_b_busy", b_busy, 1'b1);
        tick();
        chk1("tie1_pb_we", peripheralBus_we, 1'b1);
        chk("tie1_pb_wdata", peripheralBus_dataWrite, 32'h1234_5678);
        chk("tie1_pb_addr", 32'(peripheralBus_address), 32'h0001_0004);
        chk1("tie1_a_busy", a_busy, 1'b0);
        chk1("tie1_b_busy", b_busy, 1'b1);
        tick();
        a_we = 1'b0;
        #1;
        chk1("tie2_pb_oe", peripheralBus_oe, 1'b1);
        chk1("tie2_pb_we", peripheralBus_we, 1'b0);
        chk("tie2_pb_addr", 32'(peripheralBus_address), 32'h0002_0008);
        chk1("tie2_b_busy", b_busy, 1'b0);
        chk("tie2_b_dataRead", b_dataRead, 32'h0000_BEEF);
        chk("tie2_a_dataRead", a_dataRead, 32'h0);
        tick();
        b_oe = 1'b0;
        #1;
        chk("tie_state_idle", 32'(dut.state), 32'(IDLE));
        a_we = 1'b1; b_oe = 1'b1;
        tick();
        chk1("tie3_pb_we", peripheralBus_we, 1'b1);
        chk("tie3_pb_addr", 32'(peripheralBus_address), 32'h0001_0004);
        tick();
        a_we = 1'b0;
        #1;
        chk1("tie4_pb_oe", peripheralBus_oe, 1'b1);
        chk("tie4_pb_addr", 32'(peripheralBus_address), 32'h0002_0008);
        tick();
        b_oe = 1'b0;

        // Stall: B read with 5 busy cycles.
        b_oe = 1'b1; b_address = 24'h04_0000;
        peripheralBus_busy = 1'b1;
        peripheralBus_dataRead = 32'h0000_5A5A;
        #1;
        chk1("stall_arb_b_busy", b_busy, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk1("stall_b_busy", b_busy, 1'b1);
            chk1("stall_pb_oe", peripheralBus_oe, 1'b1);
            chk1("stall_flag", timeoutFlag, 1'b0);
            tick();
        end
        peripheralBus_busy = 1'b0;
        #1;
        chk1("stall_done_b_busy", b_busy, 1'b0);
        chk("stall_done_data", b_dataRead, 32'h0000_5A5A);
        chk1("stall_done_flag", timeoutFlag, 1'b0);
        tick();
        b_oe = 1'b0;

        // Timeout: A stuck busy for 16 grant cycles with B pending.
        a_oe = 1'b1; a_address = 24'h05_0000;
        b_oe = 1'b1; b_address = 24'h07_0000;
        peripheralBus_busy = 1'b1;
        tick();
        for (int i = 1; i <= 15; i++) begin
            chk1("to_wait_a_busy", a_busy, 1'b1);
            chk1("to_wait_pb_oe", peripheralBus_oe, 1'b1);
            chk1("to_wait_flag", timeoutFlag, 1'b0);
            chk1("to_wait_b_busy", b_busy, 1'b1);
            tick();
        end
        chk1("to_abort_a_busy", a_busy, 1'b0);
        chk("to_abort_data", a_dataRead, 32'hFFFF_FFFF);
        chk1("to_abort_flag", timeoutFlag, 1'b1);
        chk1("to_abort_pb_oe", peripheralBus_oe, 1'b0);
        tick();
        a_oe = 1'b0;
        #1;
        chk1("to_next_pb_oe", peripheralBus_oe, 1'b1);
        chk("to_next_pb_addr", 32'(peripheralBus_address), 32'h0007_0000);
        chk1("to_next_flag", timeoutFlag, 1'b0);
        chk1("to_next_b_busy", b_busy, 1'b1);
        peripheralBus_busy = 1'b0;
        tick();
        b_oe = 1'b0;

        // Withdraw: A drops oe while the peripheral is busy.
        a_oe = 1'b1; a_address = 24'h01_0000;
        peripheralBus_busy = 1'b1;
        tick();
        chk1("wd_pb_oe", peripheralBus_oe, 1'b1);
        a_oe = 1'b0;
        #1;
        chk1("wd_flag", timeoutFlag, 1'b0);
        tick();
        chk("wd_state_idle", 32'(dut.state), 32'(IDLE));
        chk1("wd_idle_flag", timeoutFlag, 1'b0);
        chk1("wd_idle_pb_oe", peripheralBus_oe, 1'b0);

        // Reset in the middle of a B grant.
        b_oe = 1'b1; b_address = 24'h06_0000;
        tick();
        chk1("mr_pb_oe", peripheralBus_oe, 1'b1);
        chk("mr_pb_addr", 32'(peripheralBus_address), 32'h0006_0000);
        rst = 1'b1;
        #1;
        chk1("mr_rst_pb_oe", peripheralBus_oe, 1'b0);
        chk("mr_rst_pb_addr", 32'(peripheralBus_address), 32'h0);
        chk1("mr_rst_b_busy", b_busy, 1'b1);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_state_idle", 32'(dut.state), 32'(IDLE));
        chk("mr_pb_addr_after", 32'(peripheralBus_address), 32'h0);
        chk1("mr_pb_oe_after", peripheralBus_oe, 1'b0);
        chk1("mr_b_busy_after", b_busy, 1'b1);
        b_oe = 1'b0;
        peripheralBus_busy = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
